// File: rtl/serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_compare_ctrl
//  Description : Sequences a shared 1-bit G/Eq/L comparator cell across two
//                WIDTH-bit unsigned operands, MSB first, one bit per
//                DRIVE/SAMPLE pair. Stops at the first differing bit and
//                reports a registered G/Eq/L (or fault) with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_g,
  input  logic             cmp_eq,
  input  logic             cmp_l,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             Eq,
  output logic             L,
  output logic             fault
);

  // Bit index counter width; WIDTH >= 2 so $clog2 is at least 1.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] C_IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cmp_a_q, cmp_a_d;
  logic             cmp_b_q, cmp_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             g_q, g_d;
  logic             eq_q, eq_d;
  logic             l_q, l_d;
  logic             fault_q, fault_d;

  logic [IDX_W-1:0] w_idx_dec;
  logic [2:0]       w_cell;

  assign w_idx_dec = idx_q - IDX_W'(1);
  assign w_cell    = {cmp_g, cmp_eq, cmp_l};

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    idx_d   = idx_q;
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    g_d     = g_q;
    eq_d    = eq_q;
    l_d     = l_q;
    fault_d = fault_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a_in;
          opb_d   = b_in;
          idx_d   = C_IDX_MSB;
          cmp_a_d = a_in[WIDTH-1];
          cmp_b_d = b_in[WIDTH-1];
          g_d     = 1'b0;
          eq_d    = 1'b0;
          l_d     = 1'b0;
          fault_d = 1'b0;
          state_d = S_DRIVE;
        end
      end

      // Settle cycle: the cell's gate delays resolve while the bit is held.
      S_DRIVE: begin
        state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        unique case (w_cell)
          3'b100: begin
            g_d     = 1'b1;
            state_d = S_DONE;
          end
          3'b001: begin
            l_d     = 1'b1;
            state_d = S_DONE;
          end
          3'b010: begin
            if (idx_q == '0) begin
              eq_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d   = w_idx_dec;
              cmp_a_d = opa_q[w_idx_dec];
              cmp_b_d = opb_q[w_idx_dec];
              state_d = S_DRIVE;
            end
          end
          // Non-one-hot cell response: flag it and leave G/Eq/L cleared.
          default: begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered so they line up with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers. rst_n is expected to come from an upstream
  // synchroniser, so its release is already aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      idx_q   <= C_IDX_MSB;
      cmp_a_q <= 1'b0;
      cmp_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      eq_q    <= 1'b0;
      l_q     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      idx_q   <= idx_d;
      cmp_a_q <= cmp_a_d;
      cmp_b_q <= cmp_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      g_q     <= g_d;
      eq_q    <= eq_d;
      l_q     <= l_d;
      fault_q <= fault_d;
    end
  end

  assign cmp_a = cmp_a_q;
  assign cmp_b = cmp_b_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign G     = g_q;
  assign Eq    = eq_q;
  assign L     = l_q;
  assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_compare_ctrl
//  Description : Scoreboard bench for serial_compare_ctrl with a behavioural
//                1-bit comparator cell and a word-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_compare_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             cmp_a, cmp_b;
  logic             cmp_g, cmp_eq, cmp_l;
  logic             busy, done, G, Eq, L, fault;
  logic             force_fault = 1'b0;

  typedef struct {
    logic g;
    logic eq;
    logic l;
    logic f;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   dones = 0;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g), .cmp_eq(cmp_eq), .cmp_l(cmp_l),
    .busy(busy), .done(done), .G(G), .Eq(Eq), .L(L), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1-bit comparator cell; force_fault makes G and L both assert.
  assign cmp_g  = force_fault ? 1'b1 : (cmp_a & ~cmp_b);
  assign cmp_eq = force_fault ? 1'b0 : ~(cmp_a ^ cmp_b);
  assign cmp_l  = force_fault ? 1'b1 : (~cmp_a & cmp_b);

  // Word-level reference: result from unsigned compare, latency from the
  // MSB-first position of the first differing bit.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic flt);
    exp_t e;
    int   j;
    e.g = 1'b0; e.eq = 1'b0; e.l = 1'b0; e.f = 1'b0; e.lat = 0; e.acc = 0;
    if (flt) begin
      e.f = 1'b1;
      e.lat = 3;
    end else if (a == b) begin
      e.eq = 1'b1;
      e.lat = 2 * WIDTH + 1;
    end else begin
      j = 0;
      while (a[WIDTH-1-j] == b[WIDTH-1-j]) j++;
      e.g = (a > b);
      e.l = (a < b);
      e.lat = 3 + 2 * j;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL idle_wait busy=%b required=0", busy);
    end
  endtask

  // Issue one request; returns at the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic flt);
    exp_t e;
    wait_idle();
    e = model(a, b, flt);
    e.acc = cyc;
    force_fault = flt;
    a_in = a; b_in = b; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done and checks result and latency.
  initial begin
    exp_t e;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          dones++;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done GEqLf=%b%b%b%b required=no_done", G, Eq, L, fault);
          end else begin
            e = sb.pop_front();
            checks++;
            if ({G, Eq, L, fault} !== {e.g, e.eq, e.l, e.f}) begin
              failures++;
              $display("FAIL result GEqLf=%b%b%b%b required=%b%b%b%b",
                       G, Eq, L, fault, e.g, e.eq, e.l, e.f);
            end
            checks++;
            if (cyc - e.acc != e.lat) begin
              failures++;
              $display("FAIL latency got=%0d required=%0d", cyc - e.acc, e.lat);
            end
          end
          if (prev_done) begin
            checks++; failures++;
            $display("FAIL done_width done=%b for two cycles required=one", done);
          end
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int n;

    // Reset state.
    #12;
    checks++;
    if ({busy, done, G, Eq, L, fault, cmp_a, cmp_b} !== 8'b0) begin
      failures++;
      $display("FAIL reset_state outs=%b required=00000000",
               {busy, done, G, Eq, L, fault, cmp_a, cmp_b});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // MSB difference: cmp lines carry the MSB for both DRIVE and SAMPLE cycles.
    issue(8'h80, 8'h7F, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cmp_a, cmp_b} !== 2'b10) begin
        failures++;
        $display("FAIL msb_drive cycle=%0d cmp_ab=%b%b required=10", k, cmp_a, cmp_b);
      end
      if (k == 0) @(negedge clk);
    end

    issue(8'h55, 8'h55, 1'b0);
    issue(8'h12, 8'h13, 1'b0);
    issue(8'h13, 8'h12, 1'b0);

    // Cell misbehaves at the first sample.
    issue(8'hA5, 8'h3C, 1'b1);
    issue(8'hFF, 8'h00, 1'b0);

    // Start held high and operands wiggled while busy: only the captured pair counts.
    issue(8'h5A, 8'h5B, 1'b0);
    n = 0;
    while (!done && n < 100) begin
      start = 1'b1;
      a_in = WIDTH'($urandom);
      b_in = WIDTH'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL spam_wait done=%b required=1", done);
    end

    // Reset mid-operation aborts silently; the next request completes normally.
    wait_idle();
    a_in = 8'h01; b_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, G, Eq, L, fault, cmp_a, cmp_b} !== 8'b0) begin
      failures++;
      $display("FAIL reset_abort outs=%b required=00000000",
               {busy, done, G, Eq, L, fault, cmp_a, cmp_b});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'h01, 8'h00, 1'b0);

    // Randomised traffic, biased toward equal and single-bit-difference pairs.
    for (int t = 0; t < 40; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      issue(ra, rb, ($urandom_range(0, 9) == 0));
    end

    wait_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_done pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
